// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_unit
// Purpose  : Multi-cycle control FSM for the 19-bit CPU. Sequences
//            FETCH / DECODE / EXECUTE / MEM / WRITEBACK with stall-tolerant
//            instruction and data memory handshakes, plus branch, jump,
//            halt, illegal-opcode trap and a retired-instruction counter.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            instr_opcode        - opcode field from instruction memory
//            imem_ready          - instruction memory data valid
//            dmem_ready          - data memory access completes
//            alu_zero            - ALU zero flag (used in EXECUTE of BEQ)
//            imem_req, ir_write, pc_write, pc_src
//                                - fetch / instruction register / PC control
//            alu_op, alu_src     - ALU operation and operand select
//            reg_write, mem_read, mem_write, mem_to_reg
//                                - register file and data memory control
//            halted, illegal_op  - status: core halted, undefined opcode pulse
//            retired             - completed-instruction count (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control_unit #(
    parameter int OPCODE_W = 5,
    parameter int ALU_OP_W = 4,
    parameter int RET_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] instr_opcode,
    input  logic                imem_ready,
    input  logic                dmem_ready,
    input  logic                alu_zero,
    output logic                imem_req,
    output logic                ir_write,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                alu_src,
    output logic                reg_write,
    output logic                mem_read,
    output logic                mem_write,
    output logic                mem_to_reg,
    output logic                halted,
    output logic                illegal_op,
    output logic [RET_W-1:0]    retired
);

    localparam logic [2:0] c_st_fetch   = 3'd0;
    localparam logic [2:0] c_st_decode  = 3'd1;
    localparam logic [2:0] c_st_execute = 3'd2;
    localparam logic [2:0] c_st_mem     = 3'd3;
    localparam logic [2:0] c_st_wb      = 3'd4;
    localparam logic [2:0] c_st_halt    = 3'd5;

    logic [2:0]          r_state;
    logic [2:0]          w_state_next;
    logic [OPCODE_W-1:0] r_op_q;
    logic [RET_W-1:0]    r_retired;
    logic                w_retire;
    logic                w_upper_zero;
    logic [4:0]          w_op5;
    logic                w_is_r, w_is_addi, w_is_subi, w_is_ld, w_is_st;
    logic                w_is_beq, w_is_jmp, w_is_halt, w_is_exec;
    logic [3:0]          w_alu4;
    logic                w_alu_src;

    // Opcode bits above the 5-bit base encoding must be zero to be legal.
    generate
        if (OPCODE_W > 5) begin : g_op_upper
            assign w_upper_zero = ~|r_op_q[OPCODE_W-1:5];
        end else begin : g_op_exact
            assign w_upper_zero = 1'b1;
        end
    endgenerate

    assign w_op5     = r_op_q[4:0];
    assign w_is_r    = w_upper_zero && (w_op5[4:3] == 2'b00);
    assign w_is_addi = w_upper_zero && (w_op5 == 5'b01000);
    assign w_is_subi = w_upper_zero && (w_op5 == 5'b01001);
    assign w_is_ld   = w_upper_zero && (w_op5 == 5'b01010);
    assign w_is_st   = w_upper_zero && (w_op5 == 5'b01011);
    assign w_is_beq  = w_upper_zero && (w_op5 == 5'b01100);
    assign w_is_jmp  = w_upper_zero && (w_op5 == 5'b01101);
    assign w_is_halt = w_upper_zero && (w_op5 == 5'b11111);
    assign w_is_exec = w_is_r | w_is_addi | w_is_subi | w_is_ld | w_is_st |
                       w_is_beq | w_is_jmp;

    // ALU setting chosen in EXECUTE; MEM and WRITEBACK keep presenting it so
    // the datapath result stays stable until it is consumed.
    always_comb begin
        w_alu4    = 4'b0000;
        w_alu_src = 1'b0;
        if (w_is_r) begin
            w_alu4 = w_op5[3:0];
        end else if (w_is_addi || w_is_ld || w_is_st) begin
            w_alu_src = 1'b1;
        end else if (w_is_subi) begin
            w_alu4    = 4'b0001;
            w_alu_src = 1'b1;
        end else if (w_is_beq) begin
            w_alu4 = 4'b0001;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_retire     = 1'b0;
        imem_req     = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 2'd0;
        alu_op       = '0;
        alu_src      = 1'b0;
        reg_write    = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_to_reg   = 1'b0;
        halted       = 1'b0;
        illegal_op   = 1'b0;
        retired      = r_retired;

        case (r_state)
            c_st_fetch: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write     = 1'b1;
                    pc_write     = 1'b1;
                    w_state_next = c_st_decode;
                end
            end
            c_st_decode: begin
                if (w_is_exec) begin
                    w_state_next = c_st_execute;
                end else if (w_is_halt) begin
                    w_state_next = c_st_halt;
                end else begin
                    // Undefined opcode: trap pulse, then behave as a NOP
                    // that is not counted as retired.
                    illegal_op   = 1'b1;
                    w_state_next = c_st_fetch;
                end
            end
            c_st_execute: begin
                alu_op[3:0] = w_alu4;
                alu_src     = w_alu_src;
                if (w_is_beq) begin
                    pc_write     = alu_zero;
                    pc_src       = alu_zero ? 2'd1 : 2'd0;
                    w_retire     = 1'b1;
                    w_state_next = c_st_fetch;
                end else if (w_is_jmp) begin
                    pc_write     = 1'b1;
                    pc_src       = 2'd2;
                    w_retire     = 1'b1;
                    w_state_next = c_st_fetch;
                end else if (w_is_ld || w_is_st) begin
                    w_state_next = c_st_mem;
                end else begin
                    w_state_next = c_st_wb;
                end
            end
            c_st_mem: begin
                alu_op[3:0] = w_alu4;
                alu_src     = w_alu_src;
                mem_read    = w_is_ld;
                mem_write   = w_is_st;
                if (dmem_ready) begin
                    if (w_is_st) begin
                        w_retire     = 1'b1;
                        w_state_next = c_st_fetch;
                    end else begin
                        w_state_next = c_st_wb;
                    end
                end
            end
            c_st_wb: begin
                alu_op[3:0]  = w_alu4;
                alu_src      = w_alu_src;
                reg_write    = 1'b1;
                mem_to_reg   = w_is_ld;
                w_retire     = 1'b1;
                w_state_next = c_st_fetch;
            end
            c_st_halt: begin
                halted = 1'b1;
            end
            default: begin
                w_state_next = c_st_fetch;
            end
        endcase

        // Reset silences every output, including the visible counter.
        if (rst) begin
            imem_req   = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            pc_src     = 2'd0;
            alu_op     = '0;
            alu_src    = 1'b0;
            reg_write  = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            mem_to_reg = 1'b0;
            halted     = 1'b0;
            illegal_op = 1'b0;
            retired    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_st_fetch;
            r_op_q    <= '0;
            r_retired <= '0;
        end else begin
            r_state <= w_state_next;
            if ((r_state == c_st_fetch) && imem_ready) begin
                r_op_q <= instr_opcode;
            end
            if (w_retire) begin
                r_retired <= r_retired + RET_W'(1);
            end
        end
    end

endmodule
`default_nettype wire
